// File: rtl/harvard_mem_arbiter.sv
// Shares one single-port memory between the fetch and data channels of a Harvard core,
// with a watchdog on m_ack. Define ARB_DPRIO_EN for fixed data priority (default round-robin).
module harvard_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 16
) (
    input  logic          clk,
    input  logic          nreset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_abort,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_wr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_abort,

    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic          m_wr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_abort
);

    typedef enum logic [1:0] {
        IDLE,
        MREQ,
        MRTZ,
        RESP
    } state_t;

    state_t        state;
    logic          gnt_d;
    logic [TW-1:0] wdog;
    logic          pick_d;
    logic          chan_req;
    logic          timeout_hit;

`ifndef ARB_DPRIO_EN
    logic          last_d;
`endif

    always_comb begin
`ifdef ARB_DPRIO_EN
        pick_d = d_req;
`else
        // On a tie the channel not served last wins; a lone request always wins.
        pick_d = d_req & (~i_req | ~last_d);
`endif
    end

    assign chan_req    = gnt_d ? d_req : i_req;
    assign timeout_hit = (TIMEOUT != 0) && (wdog == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            gnt_d   <= 1'b0;
`ifndef ARB_DPRIO_EN
            last_d  <= 1'b1;
`endif
            wdog    <= '0;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            i_abort <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_abort <= 1'b0;
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_wr    <= 1'b0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((i_req | d_req) & ~m_ack) begin
                        gnt_d   <= pick_d;
                        m_addr  <= pick_d ? d_addr : i_addr;
                        m_wr    <= pick_d & d_wr;
                        m_wdata <= pick_d ? d_wdata : '0;
                        m_req   <= 1'b1;
                        state   <= MREQ;
                    end
                end

                MREQ: begin
                    wdog <= wdog + TW'(1);
                    if (m_ack) begin
                        if (gnt_d) begin
                            d_rdata <= m_rdata;
                            d_abort <= m_abort;
                        end else begin
                            i_rdata <= m_rdata;
                            i_abort <= m_abort;
                        end
                        m_req <= 1'b0;
                        state <= MRTZ;
                    end else if (timeout_hit) begin
                        // Abandon the access and answer the requester directly.
                        if (gnt_d) begin
                            d_rdata <= '0;
                            d_abort <= 1'b1;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= '0;
                            i_abort <= 1'b1;
                            i_ack   <= 1'b1;
                        end
                        m_req <= 1'b0;
                        state <= RESP;
                    end
                end

                MRTZ: begin
                    if (!m_ack) begin
                        if (gnt_d) d_ack <= 1'b1;
                        else       i_ack <= 1'b1;
                        state <= RESP;
                    end
                end

                RESP: begin
                    if (!chan_req) begin
                        i_ack  <= 1'b0;
                        d_ack  <= 1'b0;
`ifndef ARB_DPRIO_EN
                        last_d <= gnt_d;
`endif
                        wdog   <= '0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_mem_arbiter.sv
// Directed testbench for harvard_mem_arbiter: fetch, store, arbitration, watchdog,
// memory abort and asynchronous reset, with hand-computed expectations.
module tb_harvard_mem_arbiter;

    logic        clk;
    logic        nreset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_abort;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_abort;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_abort;

    int checks = 0;
    int errors = 0;

    harvard_mem_arbiter #(
        .AW(32),
        .DW(32),
        .TIMEOUT(8),
        .TW(16)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ack(i_ack),
        .i_rdata(i_rdata),
        .i_abort(i_abort),
        .d_req(d_req),
        .d_addr(d_addr),
        .d_wr(d_wr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .d_abort(d_abort),
        .m_req(m_req),
        .m_addr(m_addr),
        .m_wr(m_wr),
        .m_wdata(m_wdata),
        .m_ack(m_ack),
        .m_rdata(m_rdata),
        .m_abort(m_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A requester must hold req while the memory access is outstanding.
    assert property (@(posedge clk) disable iff (!nreset) m_req |-> (i_req || d_req))
        else $error("protocol violation: m_req high with no request held");
    assert property (@(posedge clk) disable iff (!nreset) !(i_ack && d_ack))
        else $error("both acks high");
    assert property (@(posedge clk) disable iff (!nreset) !(m_req && (i_ack || d_ack)))
        else $error("m_req high while a channel is acknowledged");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_wr = 0; d_wdata = '0;
        m_ack = 0; m_rdata = '0; m_abort = 0;
        #1 nreset = 1'b0;
        #1;
        checks++;
        if ({i_ack, i_abort, d_ack, d_abort, m_req, m_wr} !== 6'b0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ctrl=%b i_rdata=%h d_rdata=%h m_addr=%h m_wdata=%h, expected all zero",
                     {i_ack, i_abort, d_ack, d_abort, m_req, m_wr}, i_rdata, d_rdata, m_addr, m_wdata);
        end
        step();
        step();
        nreset = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        i_addr = 32'h100;
        i_req  = 1'b1;
        step();
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL fetch_mreq_latency: got %b, expected 1", m_req);
        end
        checks++;
        if (m_addr !== 32'h100 || m_wr !== 1'b0) begin
            errors++; $display("FAIL fetch_maddr: got addr=%h wr=%b, expected addr=00000100 wr=0", m_addr, m_wr);
        end
        step();
        step();
        m_ack = 1'b1; m_rdata = 32'hE3A00001; m_abort = 1'b0;
        step();
        checks++;
        if (m_req !== 1'b0 || i_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_mrtz: got m_req=%b i_ack=%b, expected 0 0", m_req, i_ack);
        end
        m_ack = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hE3A00001 || i_abort !== 1'b0 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: got i_ack=%b i_rdata=%h i_abort=%b d_ack=%b, expected 1 e3a00001 0 0",
                     i_ack, i_rdata, i_abort, d_ack);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_ack_fall: got %b, expected 0", i_ack);
        end
    endtask

    task automatic test_store();
        d_addr = 32'h2000; d_wr = 1'b1; d_wdata = 32'hDEADBEEF;
        d_req  = 1'b1;
        step();
        checks++;
        if (m_req !== 1'b1 || m_wr !== 1'b1 || m_wdata !== 32'hDEADBEEF || m_addr !== 32'h2000) begin
            errors++;
            $display("FAIL store_issue: got m_req=%b m_wr=%b m_wdata=%h m_addr=%h, expected 1 1 deadbeef 00002000",
                     m_req, m_wr, m_wdata, m_addr);
        end
        step();
        m_ack = 1'b1; m_abort = 1'b0;
        step();
        checks++;
        if (d_ack !== 1'b0) begin
            errors++; $display("FAIL store_ack_early: got d_ack=%b while m_ack high, expected 0", d_ack);
        end
        m_ack = 1'b0;
        step();
        checks++;
        if (d_ack !== 1'b1 || d_abort !== 1'b0 || i_ack !== 1'b0) begin
            errors++; $display("FAIL store_resp: got d_ack=%b d_abort=%b i_ack=%b, expected 1 0 0", d_ack, d_abort, i_ack);
        end
        d_req = 1'b0; d_wr = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d;
        logic       gd;
        int         n;
`ifdef ARB_DPRIO_EN
        exp_d = 4'b1111;
`else
        exp_d = 4'b1010;
`endif
        i_addr = 32'h200; d_addr = 32'h3000; d_wr = 1'b0; d_wdata = '0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (m_req !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            checks++;
            if (m_req !== 1'b1) begin
                errors++; $display("FAIL b2b_grant_wait[%0d]: got m_req=%b after %0d cycles, expected 1", k, m_req, n);
            end
            gd = (m_addr == 32'h3000);
            checks++;
            if (gd !== exp_d[k]) begin
                errors++; $display("FAIL b2b_grant_order[%0d]: got data=%b, expected data=%b", k, gd, exp_d[k]);
            end
            step();
            m_ack = 1'b1; m_rdata = 32'hA0000000 + 32'(k);
            step();
            m_ack = 1'b0; m_rdata = '0;
            step();
            checks++;
            if ((gd ? d_ack : i_ack) !== 1'b1 || (gd ? i_ack : d_ack) !== 1'b0 ||
                (gd ? d_rdata : i_rdata) !== 32'hA0000000 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got i_ack=%b d_ack=%b rdata=%h, expected granted ack only, rdata=%h",
                         k, i_ack, d_ack, gd ? d_rdata : i_rdata, 32'hA0000000 + 32'(k));
            end
            if (gd) d_req = 1'b0;
            else    i_req = 1'b0;
            if (k == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            step();
            if (k < 3) begin
                if (gd) d_req = 1'b1;
                else    i_req = 1'b1;
            end
        end
        step();
    endtask

    task automatic test_timeout();
        d_addr = 32'h2400; d_wr = 1'b0; d_req = 1'b1;
        step();
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL timeout_issue: got m_req=%b, expected 1", m_req);
        end
        repeat (7) step();
        checks++;
        if (m_req !== 1'b1 || d_ack !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got m_req=%b d_ack=%b after 8 MREQ cycles, expected 1 0", m_req, d_ack);
        end
        step();
        checks++;
        if (m_req !== 1'b0 || d_ack !== 1'b1 || d_abort !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort: got m_req=%b d_ack=%b d_abort=%b d_rdata=%h, expected 0 1 1 00000000",
                     m_req, d_ack, d_abort, d_rdata);
        end
        d_req = 1'b0;
        step();
        m_ack = 1'b1; m_rdata = 32'h5555AAAA;
        i_addr = 32'h500; i_req = 1'b1;
        step();
        step();
        checks++;
        if (m_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
            errors++; $display("FAIL late_ack_blocks: got m_req=%b i_ack=%b d_ack=%b, expected 0 0 0", m_req, i_ack, d_ack);
        end
        m_ack = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h500) begin
            errors++; $display("FAIL late_ack_grant: got m_req=%b m_addr=%h, expected 1 00000500", m_req, m_addr);
        end
        checks++;
        if (d_abort !== 1'b1 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL data_regs_held: got d_abort=%b d_rdata=%h, expected 1 00000000", d_abort, d_rdata);
        end
        step();
        m_ack = 1'b1; m_rdata = 32'h11111111;
        step();
        m_ack = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h11111111 || i_abort !== 1'b0) begin
            errors++; $display("FAIL post_timeout_fetch: got i_ack=%b i_rdata=%h i_abort=%b, expected 1 11111111 0",
                               i_ack, i_rdata, i_abort);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_mem_abort();
        i_addr = 32'h4000; i_req = 1'b1;
        step();
        step();
        m_ack = 1'b1; m_abort = 1'b1; m_rdata = 32'h00000BAD;
        step();
        m_ack = 1'b0; m_abort = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_abort !== 1'b1) begin
            errors++; $display("FAIL mem_abort: got i_ack=%b i_abort=%b, expected 1 1", i_ack, i_abort);
        end
        step();
        checks++;
        if (i_ack !== 1'b1 || i_abort !== 1'b1) begin
            errors++; $display("FAIL mem_abort_hold: got i_ack=%b i_abort=%b, expected 1 1", i_ack, i_abort);
        end
        i_req = 1'b0;
        step();
        i_addr = 32'h4004; i_req = 1'b1;
        step();
        step();
        m_ack = 1'b1; m_rdata = 32'h12345678;
        step();
        m_ack = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_abort !== 1'b0 || i_rdata !== 32'h12345678) begin
            errors++; $display("FAIL mem_abort_next: got i_ack=%b i_abort=%b i_rdata=%h, expected 1 0 12345678",
                               i_ack, i_abort, i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        d_addr = 32'h2800; d_wr = 1'b1; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        step();
        step();
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_setup: got m_req=%b, expected 1", m_req);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 || m_wr !== 1'b0 || m_addr !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async: got m_req=%b i_ack=%b d_ack=%b m_wr=%b m_addr=%h, expected all 0",
                               m_req, i_ack, d_ack, m_wr, m_addr);
        end
        d_req = 1'b0; d_wr = 1'b0;
        step();
        #2 nreset = 1'b1;
        step();
        i_addr = 32'h600; i_req = 1'b1;
        step();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h600 || m_wr !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fresh_issue: got m_req=%b m_addr=%h m_wr=%b, expected 1 00000600 0",
                               m_req, m_addr, m_wr);
        end
        m_ack = 1'b1; m_rdata = 32'h0000600D;
        step();
        m_ack = 1'b0; m_rdata = '0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h0000600D || d_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fresh_resp: got i_ack=%b i_rdata=%h d_ack=%b, expected 1 0000600d 0",
                               i_ack, i_rdata, d_ack);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ack_fall: got %b, expected 0", i_ack);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_mem_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
        $fatal(1, "time limit");
    end

endmodule
